ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) to the keyboard.

---
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device byte transmitter (inhibit, request, frame, ACK).
//            Define PS2_TX_RETRY_EN to allow one automatic retry before error.
// Revision : 1.0
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    output logic       send_ready,
    output logic       done,
    output logic       error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [TW-1:0] C_TIMEOUT  = TW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] C_INH_LAST = IW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4,
        S_ACK       = 3'd5,
        S_WAIT_IDLE = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    state_t        state_q;
    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          clk_prev_q;
    logic [8:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic [IW-1:0] inh_cnt_q;
    logic [TW-1:0] tmo_cnt_q;
`ifdef PS2_TX_RETRY_EN
    logic          retry_q;
`endif

    logic clk_s;
    logic dat_s;
    logic clk_fall;
    logic tmo_window;

    assign clk_s      = clk_sync_q[1];
    assign dat_s      = dat_sync_q[1];
    assign clk_fall   = clk_prev_q & ~clk_s;
    assign tmo_window = (state_q == S_REQ)  || (state_q == S_DATA) ||
                        (state_q == S_STOP) || (state_q == S_ACK)  ||
                        (state_q == S_WAIT_IDLE);

    // Synchronizers reset to the idle bus level so release of reset makes no false edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q <= clk_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            send_ready <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (tmo_window && (tmo_cnt_q == '0)) begin
                state_q    <= S_FAIL;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
            end else begin
                if (tmo_window) begin
                    tmo_cnt_q <= tmo_cnt_q - TW'(1);
                end
                case (state_q)
                    S_IDLE: begin
                        if (send_valid && send_ready) begin
                            shift_q    <= {~^send_data, send_data};
                            state_q    <= S_INHIBIT;
                            send_ready <= 1'b0;
                            busy       <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            inh_cnt_q  <= '0;
`ifdef PS2_TX_RETRY_EN
                            retry_q    <= 1'b0;
`endif
                        end
                    end
                    S_INHIBIT: begin
                        if (inh_cnt_q == C_INH_LAST) begin
                            state_q    <= S_REQ;
                            ps2_clk_oe <= 1'b0;
                            ps2_dat_oe <= 1'b1;
                            tmo_cnt_q  <= C_TIMEOUT;
                            bit_cnt_q  <= '0;
                        end else begin
                            inh_cnt_q <= inh_cnt_q + IW'(1);
                        end
                    end
                    S_REQ, S_DATA: begin
                        // Data only changes just after a device falling edge
                        if (clk_fall) begin
                            ps2_dat_oe <= ~shift_q[0];
                            shift_q    <= {1'b0, shift_q[8:1]};
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            if (state_q == S_REQ) begin
                                state_q <= S_DATA;
                            end else if (bit_cnt_q == 4'd8) begin
                                state_q <= S_STOP;
                            end
                        end
                    end
                    S_STOP: begin
                        if (clk_fall) begin
                            ps2_dat_oe <= 1'b0;
                            bit_cnt_q  <= 4'd10;
                            state_q    <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (clk_fall) begin
                            bit_cnt_q <= 4'd11;
                            state_q   <= dat_s ? S_FAIL : S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (clk_s && dat_s) begin
                            state_q    <= S_IDLE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            send_ready <= 1'b1;
                        end
                    end
                    S_FAIL: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                        if (!retry_q) begin
                            retry_q    <= 1'b1;
                            state_q    <= S_INHIBIT;
                            ps2_clk_oe <= 1'b1;
                            inh_cnt_q  <= '0;
                        end else begin
                            state_q    <= S_IDLE;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            send_ready <= 1'b1;
                        end
`else
                        state_q    <= S_IDLE;
                        error      <= 1'b1;
                        busy       <= 1'b0;
                        send_ready <= 1'b1;
`endif
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 3000;
    localparam int HP  = 8;

`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send_valid = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       send_ready, done, error, busy, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_rel = 1'b1;
    logic       dev_dat_rel = 1'b1;
    logic       ps2_clk_line, ps2_dat_line;

    assign ps2_clk_line = dev_clk_rel & ~ps2_clk_oe;
    assign ps2_dat_line = dev_dat_rel & ~ps2_dat_oe;

    always #5 clock = ~clock;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .send_valid (send_valid),
        .send_data  (send_data),
        .send_ready (send_ready),
        .done       (done),
        .error      (error),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_line),
        .ps2_dat_in (ps2_dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (done && error) both_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    task automatic send(input logic [7:0] d);
        int n = 0;
        @(negedge clock);
        while (!send_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        send_valid = 1'b1;
        send_data  = d;
        @(negedge clock);
        send_valid = 1'b0;
        send_data  = 8'($urandom);
    endtask

    task automatic wait_request(output bit ok);
        int n = 0;
        while (!(ps2_dat_oe && !ps2_clk_oe) && n < INH + 200) begin
            @(negedge clock);
            n++;
        end
        ok = ps2_dat_oe && !ps2_clk_oe;
    endtask

    task automatic device(input bit ack, output logic [10:0] bits, output bit ok);
        bits = '0;
        wait_request(ok);
        if (ok) begin
            bits[0] = ps2_dat_line;
            repeat (HP) @(negedge clock);
            for (int k = 1; k <= 11; k++) begin
                dev_clk_rel = 1'b0;
                repeat (HP) @(negedge clock);
                dev_clk_rel = 1'b1;
                if (k <= 10) bits[k] = ps2_dat_line;
                if (k == 10 && ack) dev_dat_rel = 1'b0;
                repeat (HP) @(negedge clock);
                if (k == 11) dev_dat_rel = 1'b1;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("busy_released", busy, 0);
        repeat (2) @(negedge clock);
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit ack,
                            output logic [10:0] bits, output int dd, output int de);
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        logic [10:0] b2;
        send(d);
        device(ack, bits, ok);
        chk("request_seen", ok, 1);
        chk("frame", bits, model_frame(d));
        if (!ack) begin
            for (int a = 1; a < ATTEMPTS; a++) begin
                device(1'b0, b2, ok);
                chk("retry_request_seen", ok, 1);
                chk("retry_frame", b2, model_frame(d));
            end
        end
        wait_idle();
        dd = done_cnt - d0;
        de = err_cnt - e0;
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        logic [10:0] exp_frame;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [10:0] bits;
        int dd, de, n, d0, e0;
        bit ok;

        tbl[0] = '{8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1, 0};
        tbl[1] = '{8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 1, 0};
        tbl[2] = '{8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1, 0};
        tbl[3] = '{8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1, 0};
        tbl[4] = '{8'h80, 1'b1, {1'b1, 1'b0, 8'h80, 1'b0}, 1, 0};
        tbl[5] = '{8'hA5, 1'b0, {1'b1, 1'b1, 8'hA5, 1'b0}, 0, 1};

        repeat (3) @(negedge clock);
        chk("reset_outputs", {send_ready, done, error, busy, ps2_clk_oe, ps2_dat_oe}, 6'b100000);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_reset_outputs", {send_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);

        // Device clocks while idle must not disturb the host
        for (int p = 0; p < 3; p++) begin
            dev_clk_rel = 1'b0;
            repeat (HP) @(negedge clock);
            chk("idle_no_drive", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
            dev_clk_rel = 1'b1;
            repeat (HP) @(negedge clock);
        end

        for (int i = 0; i < 6; i++) begin
            run_xfer(tbl[i].data, tbl[i].ack, bits, dd, de);
            chk("tbl_frame", bits, tbl[i].exp_frame);
            chk("tbl_done", dd, tbl[i].exp_done);
            chk("tbl_error", de, tbl[i].exp_err);
        end

        // Inhibit length and request
        send(8'h3C);
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < INH + 50) begin
            @(negedge clock);
            n++;
        end
        chk("inhibit_cycles", n, INH);
        chk("request_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        d0 = done_cnt;
        device(1'b1, bits, ok);
        chk("inhibit_frame", bits, model_frame(8'h3C));
        wait_idle();
        chk("inhibit_done", done_cnt - d0, 1);

        // Device never clocks: timeout
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h55);
        n = 0;
        while (!error && n < ATTEMPTS * (INH + TMO) + 100) begin
            @(negedge clock);
            n++;
        end
        chk("timeout_error_seen", error, 1);
        chk("timeout_lines_released", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
        chk("timeout_window", (n >= ATTEMPTS * (INH + TMO)) && (n <= ATTEMPTS * (INH + TMO) + 4 * ATTEMPTS), 1);
        repeat (3) @(negedge clock);
        chk("timeout_error_count", err_cnt - e0, 1);
        chk("timeout_no_done", done_cnt - d0, 0);

        // Reset while the host drives data bit 4
        send(8'h0F);
        wait_request(ok);
        chk("rst_request_seen", ok, 1);
        repeat (HP) @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            dev_clk_rel = 1'b0;
            repeat (HP) @(negedge clock);
            dev_clk_rel = 1'b1;
            repeat (HP) @(negedge clock);
        end
        dev_clk_rel = 1'b0;
        repeat (4) @(negedge clock);
        chk("pre_reset_bit4_driven", ps2_dat_oe, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        reset = 1'b1;
        #1;
        chk("async_reset_lines", {ps2_clk_oe, ps2_dat_oe, send_ready, busy}, 4'b0010);
        @(negedge clock);
        dev_clk_rel = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (HP) @(negedge clock);
        chk("reset_no_pulses", {done_cnt - d0, err_cnt - e0}, 0);
        run_xfer(8'hFF, 1'b1, bits, dd, de);
        chk("after_reset_done", dd, 1);
        chk("after_reset_error", de, 0);

        // Randomized bytes and ACK behaviour against the frame model
        for (int r = 0; r < 16; r++) begin
            logic [7:0] d;
            bit ack;
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            run_xfer(d, ack, bits, dd, de);
            chk("rand_done", dd, ack ? 1 : 0);
            chk("rand_error", de, ack ? 0 : 1);
        end

        chk("done_error_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
